off_gesture_detector: RTL

//  Upstream front end of the OFF-mode event stage. Synchronises and debounces the

---
 rtl/off_gesture_detector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/off_gesture_detector.sv
// Front end of the OFF-mode event stage: per-key synchroniser and debouncer feeding
// the power-on gesture FSM (left key arms the standby timer, right key inside the window).
module off_gesture_detector #(
  parameter int unsigned           MODE_WIDTH      = 3,
  parameter int unsigned           MAX_WIDTH       = 32,
  parameter logic [MODE_WIDTH-1:0] OFF_CODE        = {MODE_WIDTH{1'b0}},
  parameter logic [19:0]           DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [2:0]            LOAD_WAIT       = 3'd4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic                  key_left_raw,
  input  logic                  key_right_raw,
  input  logic [MAX_WIDTH-1:0]  off_output_time,
  output logic                  first_toggle_signal,
  output logic                  standby_req,
  output logic                  gesture_timeout,
  output logic                  gesture_active
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_WINDOW = 2'd2
  } state_e;

  // Index 0 = left key, index 1 = right key
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       press_q, press_d;
  logic [1:0][19:0] cnt_q, cnt_d;

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       first_toggle_q, first_toggle_d;
  logic       standby_q, standby_d;
  logic       timeout_q, timeout_d;
  logic       active_q, active_d;

  logic in_off_s;
  logic time_nz_s;
  logic load_expired_s;

  assign in_off_s       = (current_mode == OFF_CODE);
  assign time_nz_s      = |off_output_time;
  assign load_expired_s = (wait_q == (LOAD_WAIT - 3'd1));

  // Two-flop synchronisers for the asynchronous key inputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {key_right_raw, key_left_raw};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    press_d = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = 20'd0;
      end else if (cnt_q[k] == (DEBOUNCE_CYCLES - 20'd1)) begin
        cnt_d[k]   = 20'd0;
        deb_d[k]   = sync2_q[k];
        press_d[k] = sync2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 20'd1;
      end
    end
  end

  // Debounced levels, counters and press pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_q   <= 2'b00;
      cnt_q   <= '0;
      press_q <= 2'b00;
    end else begin
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // FSM state register together with its registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      wait_q         <= 3'd0;
      first_toggle_q <= 1'b0;
      standby_q      <= 1'b0;
      timeout_q      <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      first_toggle_q <= first_toggle_d;
      standby_q      <= standby_d;
      timeout_q      <= timeout_d;
      active_q       <= active_d;
    end
  end

  // Next-state logic; leaving OFF mode overrides every other transition
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!in_off_s) begin
      state_d = ST_IDLE;
      wait_d  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_q[0]) begin
            state_d = ST_ARMED;
            wait_d  = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (time_nz_s) begin
            state_d = ST_WINDOW;
          end else if (load_expired_s) begin
            state_d = ST_IDLE;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
        ST_WINDOW: begin
          if (!time_nz_s || press_q[1]) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WINDOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wait_d  = 3'd0;
        end
      endcase
    end
  end

  // Output decode, registered alongside the state so pulses align with transitions
  always_comb begin
    first_toggle_d = 1'b0;
    standby_d      = 1'b0;
    timeout_d      = 1'b0;
    active_d       = (state_d == ST_ARMED) || (state_d == ST_WINDOW);
    if (in_off_s) begin
      case (state_q)
        ST_IDLE:   first_toggle_d = press_q[0];
        ST_ARMED:  timeout_d      = !time_nz_s && load_expired_s;
        ST_WINDOW: begin
          standby_d = time_nz_s && press_q[1];
          timeout_d = !time_nz_s;
        end
        default: begin
          first_toggle_d = 1'b0;
        end
      endcase
    end else begin
      first_toggle_d = 1'b0;
    end
  end

  assign first_toggle_signal = first_toggle_q;
  assign standby_req         = standby_q;
  assign gesture_timeout     = timeout_q;
  assign gesture_active      = active_q;

endmodule
